// File: rtl/syn_io_seq_rep_if.sv
// Synapse-IO controller bus used by syn_io_seq_rep.
//   master (sequencer):  drives io_start, io_opcd, io_row, io_colset; samples io_busy
//   slave  (controller): samples the issue fields; drives io_busy
interface syn_io_seq_rep_if #(
  parameter int unsigned OPCD_W   = 4,
  parameter int unsigned ROW_W    = 6,
  parameter int unsigned COLSET_W = 3
);
  logic                io_start;
  logic [OPCD_W-1:0]   io_opcd;
  logic [ROW_W-1:0]    io_row;
  logic [COLSET_W-1:0] io_colset;
  logic                io_busy;

  modport master (output io_start, io_opcd, io_row, io_colset, input io_busy);
  modport slave  (input io_start, io_opcd, io_row, io_colset, output io_busy);
endinterface

// File: rtl/syn_io_seq_rep.sv
// syn_io_seq_rep: issues up to SEQ_LEN synapse-IO opcodes back-to-back to the
// synapse-IO controller, repeating the whole sequence reps+1 times.
// Optional build macro SYN_IO_SEQ_ADDR_STEP_EN: each repeat pass advances the
// address by addr_step (mod 2^ADDR_W); without it every pass reuses the start address.
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   start          request, accepted only when idle (seq/addr/reps sampled then)
//   seq            packed opcodes, slot 0 in the MSBs; opcode 0 terminates
//   addr           start address, {row,colset} = addr[ADDR_W-1:0]
//   addr_step      per-pass address increment (used only with the macro)
//   reps           extra passes
//   abort          stop after the in-flight op
//   busy, done     sequencer active; one-cycle end-of-sequence pulse
//   io             controller bus (master side); issue fields are combinational
module syn_io_seq_rep #(
  parameter int unsigned SEQ_LEN  = 8,
  parameter int unsigned OPCD_W   = 4,
  parameter int unsigned ROW_W    = 6,
  parameter int unsigned COLSET_W = 3,
  parameter int unsigned REP_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [SEQ_LEN*OPCD_W-1:0]       seq,
  input  logic [31:0]                     addr,
  input  logic [ROW_W+COLSET_W-1:0]       addr_step,
  input  logic [REP_W-1:0]                reps,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  syn_io_seq_rep_if.master                io
);

  localparam int unsigned ADDR_W = ROW_W + COLSET_W;
  localparam int unsigned CTR_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned SEQ_W  = SEQ_LEN * OPCD_W;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    op_seq_q, op_seq_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [REP_W-1:0]    pass_q, pass_d;
  logic [REP_W-1:0]    reps_q, reps_d;
  logic [ADDR_W-1:0]   addr_cur_q, addr_cur_d;
  logic                abort_pend_q, abort_pend_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   next_addr;
  logic [OPCD_W-1:0]   in_op0, first_op, cur_op, nxt_op;
  logic                has_next;
  logic                io_start_c, busy_c;
  logic [OPCD_W-1:0]   opcd_c;
  logic [ADDR_W-1:0]   addr_out_c;

  // Slot k sits k opcodes below the MSB end.
  function automatic logic [OPCD_W-1:0] op_at(input logic [SEQ_W-1:0] s, input int unsigned k);
    return OPCD_W'(s >> ((SEQ_LEN - 1 - k) * OPCD_W));
  endfunction

  assign in_op0   = op_at(seq, 0);
  assign first_op = op_at(op_seq_q, 0);

  // Current and following slot; the following slot is only matched for ctr < SEQ_LEN-1,
  // so the last slot never looks past the end of the sequence.
  always_comb begin
    cur_op = '0;
    nxt_op = '0;
    for (int unsigned k = 0; k < SEQ_LEN; k++) begin
      if (ctr_q == CTR_W'(k)) cur_op = op_at(op_seq_q, k);
    end
    for (int unsigned k = 1; k < SEQ_LEN; k++) begin
      if (ctr_q == CTR_W'(k - 1)) nxt_op = op_at(op_seq_q, k);
    end
    has_next = (nxt_op != '0);
  end

`ifdef SYN_IO_SEQ_ADDR_STEP_EN
  assign next_addr = addr_cur_q + addr_step;
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];
`else
  assign next_addr = addr_cur_q;
  logic unused_addr_in;
  assign unused_addr_in = ^{addr[31:ADDR_W], addr_step};
`endif

  // Next-state and issue logic.
  always_comb begin
    state_d      = state_q;
    op_seq_d     = op_seq_q;
    ctr_d        = ctr_q;
    pass_d       = pass_q;
    reps_d       = reps_q;
    addr_cur_d   = addr_cur_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    io_start_c   = 1'b0;
    busy_c       = 1'b0;
    opcd_c       = '0;
    addr_out_c   = '0;

    case (state_q)
      S_IDLE: begin
        // start wins over abort here; abort alone is ignored
        if (start) begin
          if (in_op0 != '0) begin
            io_start_c   = 1'b1;
            busy_c       = 1'b1;
            opcd_c       = in_op0;
            addr_out_c   = addr[ADDR_W-1:0];
            op_seq_d     = seq;
            reps_d       = reps;
            addr_cur_d   = addr[ADDR_W-1:0];
            ctr_d        = '0;
            pass_d       = '0;
            abort_pend_d = 1'b0;
            state_d      = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        busy_c     = 1'b1;
        opcd_c     = cur_op;
        addr_out_c = addr_cur_q;
        if (io.io_busy) begin
          if (abort) abort_pend_d = 1'b1;
        end else if (abort_pend_q || abort) begin
          abort_pend_d = 1'b0;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else if (has_next) begin
          io_start_c = 1'b1;
          opcd_c     = nxt_op;
          ctr_d      = ctr_q + CTR_W'(1);
        end else if (pass_q < reps_q) begin
          io_start_c = 1'b1;
          opcd_c     = first_op;
          addr_out_c = next_addr;
          addr_cur_d = next_addr;
          ctr_d      = '0;
          pass_d     = pass_q + REP_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_seq_q     <= '0;
      ctr_q        <= '0;
      pass_q       <= '0;
      reps_q       <= '0;
      addr_cur_q   <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_seq_q     <= op_seq_d;
      ctr_q        <= ctr_d;
      pass_q       <= pass_d;
      reps_q       <= reps_d;
      addr_cur_q   <= addr_cur_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
    end
  end

  // Issue path is combinational, so hold it quiet while reset is asserted.
  assign io.io_start  = io_start_c & ~reset;
  assign io.io_opcd   = reset ? '0 : opcd_c;
  assign io.io_row    = reset ? '0 : addr_out_c[ADDR_W-1:COLSET_W];
  assign io.io_colset = reset ? '0 : addr_out_c[COLSET_W-1:0];
  assign busy         = busy_c & ~reset;
  assign done         = done_q;

endmodule

// File: tb/tb_syn_io_seq_rep.sv
// Testbench for syn_io_seq_rep: directed scenarios plus randomized sequences,
// checked against a transaction-level model (opcode/address list, done timing).
`timescale 1ns/1ps
module tb_syn_io_seq_rep;

  localparam int unsigned SEQ_LEN  = 8;
  localparam int unsigned OPCD_W   = 4;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned COLSET_W = 3;
  localparam int unsigned REP_W    = 8;

`ifdef SYN_IO_SEQ_ADDR_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort, busy, done;
  logic [31:0] seq, addr;
  logic [8:0]  addr_step;
  logic [7:0]  reps;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_left;

  syn_io_seq_rep_if #(.OPCD_W(OPCD_W), .ROW_W(ROW_W), .COLSET_W(COLSET_W)) bus ();

  syn_io_seq_rep #(
    .SEQ_LEN(SEQ_LEN), .OPCD_W(OPCD_W), .ROW_W(ROW_W), .COLSET_W(COLSET_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seq(seq), .addr(addr),
    .addr_step(addr_step), .reps(reps), .abort(abort), .busy(busy), .done(done),
    .io(bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Run one request and compare against the reference issue list.
  // lat: controller busy cycles per op (0 = random 1..4); abort_at: issue index to abort during (-1 none).
  task automatic run_seq(input string name, input logic [31:0] s, input logic [31:0] a,
                         input logic [8:0] stp, input logic [7:0] r, input int abort_at,
                         input bit start_abort, input int lat, input bit poke);
    logic [3:0] ops[$];
    logic [3:0] exp_op[$];
    logic [8:0] exp_addr[$];
    logic [3:0] obs_op[$];
    logic [8:0] obs_addr[$];
    int         iss_cyc[$];
    int         cmp_cyc[$];
    int         done_cyc[$];
    logic [8:0] pa;
    logic [3:0] o;
    int n_exp, start_cyc, busy_err, post, want;
    bit outstanding, aborted, poked, fin;

    // Reference: nonzero prefix of the slots, repeated reps+1 times, truncated by abort.
    for (int i = 0; i < int'(SEQ_LEN); i++) begin
      o = 4'(s >> (28 - 4 * i));
      if (o == 4'd0) break;
      ops.push_back(o);
    end
    pa = a[8:0];
    if (ops.size() > 0) begin
      for (int p = 0; p <= int'(r); p++) begin
        foreach (ops[i]) begin
          exp_op.push_back(ops[i]);
          exp_addr.push_back(pa);
        end
        if (STEP_EN) pa = pa + stp;
      end
    end
    n_exp = exp_op.size();
    if (abort_at >= 0 && abort_at + 1 < n_exp) n_exp = abort_at + 1;

    seq = s; addr = a; addr_step = stp; reps = r; start = 1'b1; abort = start_abort;
    start_cyc = cyc; busy_err = 0; post = 0;
    outstanding = 0; aborted = 0; poked = 0; fin = 0;

    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      if (outstanding && !bus.io_busy) begin
        cmp_cyc.push_back(cyc);
        outstanding = 0;
      end
      if (bus.io_start) begin
        obs_op.push_back(bus.io_opcd);
        obs_addr.push_back({bus.io_row, bus.io_colset});
        iss_cyc.push_back(cyc);
        outstanding = 1;
        busy_left = (lat > 0) ? lat : int'($urandom_range(1, 4));
      end
      if (done) done_cyc.push_back(cyc);
      if (done_cyc.size() == 0) begin
        if (busy !== (n_exp > 0)) busy_err++;
      end else begin
        if (busy !== 1'b0) busy_err++;
        post++;
      end
      if (post >= 3) fin = 1;

      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (busy_left > 0) begin
        bus.io_busy = 1'b1;
        busy_left--;
      end else begin
        bus.io_busy = 1'b0;
      end
      if (abort_at >= 0 && !aborted && obs_op.size() == abort_at + 1 && bus.io_busy) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (poke && !poked && obs_op.size() == 1 && bus.io_busy) begin
        start = 1'b1;
        seq = $urandom; addr = $urandom; reps = 8'($urandom);
        poked = 1;
      end
    end

    n_checks++;
    if (!fin) begin
      $display("FAIL %s timeout: no done within cycle budget", name);
      return;
    end
    n_pass++;

    n_checks++;
    if (obs_op.size() != n_exp)
      $display("FAIL %s issue_count: got %0d want %0d", name, obs_op.size(), n_exp);
    else n_pass++;

    for (int i = 0; i < n_exp && i < obs_op.size(); i++) begin
      n_checks++;
      if ({obs_op[i], obs_addr[i]} !== {exp_op[i], exp_addr[i]})
        $display("FAIL %s issue[%0d]: got op=%0h addr=%03h want op=%0h addr=%03h",
                 name, i, obs_op[i], obs_addr[i], exp_op[i], exp_addr[i]);
      else n_pass++;
      n_checks++;
      want = (i == 0) ? start_cyc : ((cmp_cyc.size() >= i) ? cmp_cyc[i-1] : -1);
      if (iss_cyc[i] != want)
        $display("FAIL %s issue_cycle[%0d]: got %0d want %0d", name, i, iss_cyc[i], want);
      else n_pass++;
    end

    n_checks++;
    if (done_cyc.size() != 1)
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cyc.size());
    else n_pass++;

    if (done_cyc.size() >= 1) begin
      if (n_exp == 0) want = start_cyc + 1;
      else want = (cmp_cyc.size() >= n_exp) ? cmp_cyc[n_exp-1] + 1 : -1;
      n_checks++;
      if (done_cyc[0] != want)
        $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc[0], want);
      else n_pass++;
    end

    n_checks++;
    if (busy_err != 0) $display("FAIL %s busy: got %0d bad cycles want 0", name, busy_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; seq = 32'h9100_0000; addr = 32'h55; abort = 1'b0;
    #3;
    n_checks++;
    if ({bus.io_start, bus.io_opcd, bus.io_row, bus.io_colset, busy, done} !== '0)
      $display("FAIL reset_outputs: got start=%b opcd=%0h row=%0h col=%0h busy=%b done=%b want all 0",
               bus.io_start, bus.io_opcd, bus.io_row, bus.io_colset, busy, done);
    else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.io_start, busy, done} !== 3'b000)
      $display("FAIL reset_release: got start=%b busy=%b done=%b want 000", bus.io_start, busy, done);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_seq("basic_345", 32'h3450_0000, 32'h0, 9'd0, 8'd0, -1, 1'b0, 3, 1'b0);
  endtask

  task automatic test_full();
    run_seq("full_8", 32'h1234_5671, 32'h12A, 9'd5, 8'd0, -1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_addr_step();
    run_seq("addr_step", 32'h2000_0000, 32'h3F, 9'd1, 8'd2, -1, 1'b0, 2, 1'b0);
  endtask

  task automatic test_wrap();
    run_seq("addr_wrap", 32'h5000_0000, 32'h1FF, 9'd2, 8'd1, -1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_abort();
    // abort while idle must not linger into the next request
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    run_seq("abort_idle", 32'h1200_0000, 32'h40, 9'd0, 8'd0, -1, 1'b0, 2, 1'b0);
    run_seq("abort_mid", 32'h1234_0000, 32'h10, 9'd0, 8'd0, 1, 1'b0, 3, 1'b0);
    run_seq("start_abort", 32'h6700_0000, 32'h22, 9'd0, 8'd0, -1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_reps", 32'hABC0_0000, 32'h1F0, 9'd9, 8'd2, -1, 1'b0, 1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    seq = 32'h7700_0000; addr = 32'h0; addr_step = 9'd0; reps = 8'd3; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    busy_left = 4;
    @(posedge clk); #1;
    start = 1'b0; bus.io_busy = 1'b1; busy_left--;
    @(posedge clk); #1;
    start = 1'b1; seq = 32'h9000_0000;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.io_start, bus.io_opcd, bus.io_row, bus.io_colset, busy} !== '0)
      $display("FAIL reset_mid_run: got start=%b opcd=%0h busy=%b want 0", bus.io_start, bus.io_opcd, busy);
    else n_pass++;
    @(negedge clk);
    bus.io_busy = 1'b0; busy_left = 0; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.io_start, busy, done} !== 3'b000)
      $display("FAIL reset_mid_run_idle: got start=%b busy=%b done=%b want 000", bus.io_start, busy, done);
    else n_pass++;
    @(posedge clk); #1;
    run_seq("empty_after_reset", 32'h0000_0000, 32'h7, 9'd0, 8'd0, -1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] s;
    int zpos, total, ab;
    for (int t = 0; t < 25; t++) begin
      zpos = $urandom_range(0, 8);
      s = '0;
      for (int i = 0; i < zpos; i++) s[31-4*i -: 4] = 4'($urandom_range(1, 15));
      reps = 8'($urandom_range(0, 3));
      total = zpos * (int'(reps) + 1);
      ab = (total > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      run_seq($sformatf("rand%0d", t), s, $urandom, 9'($urandom), reps, ab,
              1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; seq = '0; addr = '0;
    addr_step = '0; reps = '0; bus.io_busy = 1'b0; busy_left = 0;
    test_reset();
    test_basic();
    test_full();
    test_addr_step();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
